// File: rtl/hdc_pkg.sv
// rtl/hdc_pkg.sv - shared defaults, FSM states and helpers for the HDC n-gram encoder
package hdc_pkg;

    localparam int D_DEF     = 10000;
    localparam int ALPHA_DEF = 27;
    localparam int SYM_W_DEF = 5;
    localparam int CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_THRESH,
        ST_OUT
    } state_e;

    function automatic int unsigned clamp_sym(input int unsigned sym, input int unsigned alpha);
        return (sym >= alpha) ? alpha - 1 : sym;
    endfunction

    // Deterministic pseudo-random item bit, used when no explicit item image is supplied
    function automatic logic item_bit(input int unsigned sym, input int unsigned b);
        logic [31:0] x;
        x = (sym * 32'h9E37_79B9) ^ (b * 32'h85EB_CA6B) ^ 32'h5BD1_E995;
        x = x ^ (x >> 15);
        x = x * 32'h2C1B_3C6D;
        x = x ^ (x >> 12);
        return x[0];
    endfunction

endpackage

// File: rtl/hdc_item_memory.sv
// rtl/hdc_item_memory.sv - ALPHA x D item ROM with one-cycle registered read
module hdc_item_memory
    import hdc_pkg::*;
#(
    parameter int                 D         = D_DEF,
    parameter int                 ALPHA     = ALPHA_DEF,
    parameter int                 SYM_W     = SYM_W_DEF,
    parameter bit                 USE_INIT  = 1'b0,
    parameter logic [ALPHA*D-1:0] ITEM_INIT = '0
) (
    input  logic             clk,
    input  logic [SYM_W-1:0] addr_i,
    output logic [D-1:0]     item_o
);

    function automatic logic [D-1:0] default_item(input int unsigned sym);
        logic [D-1:0] v;
        for (int b = 0; b < D; b++) begin
            v[b] = item_bit(sym, b);
        end
        return v;
    endfunction

    logic [D-1:0] rom [ALPHA];

    for (genvar s = 0; s < ALPHA; s++) begin : g_rom
        assign rom[s] = USE_INIT ? ITEM_INIT[s*D +: D] : default_item(s);
    end

    always_ff @(posedge clk) begin
        item_o <= rom[addr_i];
    end

endmodule

// File: rtl/hdc_ngram_encoder.sv
// rtl/hdc_ngram_encoder.sv - trigram bind and per-bit majority bundling into one query hypervector per document
module hdc_ngram_encoder
    import hdc_pkg::*;
#(
    parameter int                 D         = D_DEF,
    parameter int                 ALPHA     = ALPHA_DEF,
    parameter int                 SYM_W     = SYM_W_DEF,
    parameter int                 N         = 3,
    parameter int                 CNT_W     = CNT_W_DEF,
    parameter bit                 USE_INIT  = 1'b0,
    parameter logic [ALPHA*D-1:0] ITEM_INIT = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tok_valid,
    output logic             tok_ready,
    input  logic [SYM_W-1:0] tok_sym,
    input  logic             tok_last,
    output logic             hv_valid,
    input  logic             hv_ready,
    output logic [D-1:0]     hv_data,
    output logic [CNT_W-1:0] hv_ngrams,
    output logic             hv_sat
);

    localparam logic [1:0]       HIST_FULL = 2'(N - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    function automatic logic [D-1:0] rotl(input logic [D-1:0] v, input int unsigned sh);
        return (v << sh) | (v >> (D - sh));
    endfunction

    state_e                  state_q, state_d;
    logic                    accept;
    logic                    pend_q;
    logic [1:0]              tokcnt_q;
    logic [SYM_W-1:0]        sym_c;
    logic [D-1:0]            item;
    logic [D-1:0]            h1_q, h2_q;
    logic [D-1:0]            ngram;
    logic [D-1:0][CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0]        n_q;
    logic                    sat_q;
    logic [D-1:0]            thresh;
    logic [D-1:0]            hv_data_q;
    logic [CNT_W-1:0]        hv_ngrams_q;
    logic                    hv_sat_q;

    assign sym_c  = SYM_W'(clamp_sym(int'(tok_sym), ALPHA));
    assign accept = tok_valid && tok_ready;
    assign ngram  = rotl(h2_q, 2) ^ rotl(h1_q, 1) ^ item;

    hdc_item_memory #(
        .D         (D),
        .ALPHA     (ALPHA),
        .SYM_W     (SYM_W),
        .USE_INIT  (USE_INIT),
        .ITEM_INIT (ITEM_INIT)
    ) u_item_mem (
        .clk    (clk),
        .addr_i (sym_c),
        .item_o (item)
    );

    // Strict majority: a tie (2*cnt == n) resolves to 0
    always_comb begin
        thresh = '0;
        for (int i = 0; i < D; i++) begin
            thresh[i] = {cnt_q[i], 1'b0} > {1'b0, n_q};
        end
    end

    always_comb begin
        state_d   = state_q;
        tok_ready = 1'b0;
        hv_valid  = 1'b0;
        case (state_q)
            ST_RUN: begin
                tok_ready = 1'b1;
                if (tok_valid && tok_last) state_d = ST_DRAIN;
            end
            ST_DRAIN:  state_d = ST_THRESH;
            ST_THRESH: state_d = ST_OUT;
            ST_OUT: begin
                hv_valid = 1'b1;
                if (hv_ready) state_d = ST_RUN;
            end
            default:   state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            pend_q      <= 1'b0;
            tokcnt_q    <= '0;
            h1_q        <= '0;
            h2_q        <= '0;
            cnt_q       <= '0;
            n_q         <= '0;
            sat_q       <= 1'b0;
            hv_data_q   <= '0;
            hv_ngrams_q <= '0;
            hv_sat_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= accept;
            if (state_q == ST_THRESH) begin
                hv_data_q   <= thresh;
                hv_ngrams_q <= n_q;
                hv_sat_q    <= sat_q;
                tokcnt_q    <= '0;
                h1_q        <= '0;
                h2_q        <= '0;
                cnt_q       <= '0;
                n_q         <= '0;
                sat_q       <= 1'b0;
            end else if (pend_q) begin
                h2_q <= h1_q;
                h1_q <= item;
                if (tokcnt_q != HIST_FULL) tokcnt_q <= tokcnt_q + 2'd1;
                // The first N-1 symbols of a document only prime the history
                if (tokcnt_q == HIST_FULL) begin
                    if (n_q == CNT_MAX) begin
                        sat_q <= 1'b1;
                    end else begin
                        n_q <= n_q + 1'b1;
                        for (int i = 0; i < D; i++) begin
                            cnt_q[i] <= cnt_q[i] + {{(CNT_W-1){1'b0}}, ngram[i]};
                        end
                    end
                end
            end
        end
    end

    assign hv_data   = hv_data_q;
    assign hv_ngrams = hv_ngrams_q;
    assign hv_sat    = hv_sat_q;

endmodule
